// File: rtl/mean_out_buffer_if.sv
// Sample/stream bundle between the mean filter, the output buffer and its consumer.
// The slave modport is the buffer's view; master is the driving environment.
interface mean_out_buffer_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              en;
    logic [DATA_W-1:0] sample;
    logic              done;
    logic              flush;
    logic              clr_ovf;
    logic              ready;
    logic [DATA_W-1:0] head;
    logic              valid;
    logic [CW-1:0]     count;
    logic              ovf;

    modport master (
        output en, sample, done, flush, clr_ovf, ready,
        input  head, valid, count, ovf
    );

    modport slave (
        input  en, sample, done, flush, clr_ovf, ready,
        output head, valid, count, ovf
    );
endinterface

// File: rtl/mean_out_buffer.sv
// Decimating first-word-fall-through FIFO behind the mean filter, with a sticky
// overflow flag for kept samples that found the FIFO full.
module mean_out_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int DECIM  = 1
) (
    input  logic               clk,
    input  logic               rst,
    mean_out_buffer_if.slave   bus
);
    localparam int             PW       = $clog2(DEPTH);
    localparam int             CW       = PW + 1;
    localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
    localparam logic [3:0]     DLAST    = 4'(DECIM - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [3:0]        dcnt;
    logic              ovf;
    logic              wr_req;
    logic              pop;
    logic              full;
    logic              wr_acc;
    logic              drop;

    // A flush cancels both the write and the pop of its cycle, and a discarded write is not an overflow.
    always_comb begin
        wr_req = bus.done & bus.en & (dcnt == 4'd0);
        pop    = (count != '0) & bus.ready;
        full   = (count == FULL_CNT);
        wr_acc = wr_req & (~full | pop) & ~bus.flush;
        drop   = wr_req & full & ~pop & ~bus.flush;
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.en) begin
            dcnt <= 4'd0;
        end else if (bus.done) begin
            dcnt <= (dcnt == DLAST) ? 4'd0 : dcnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
            if (pop)    rd_ptr <= rd_ptr + PW'(1);
            case ({wr_acc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc && !rst) begin
            mem[wr_ptr] <= bus.sample;
        end
    end

    // A new drop outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            ovf <= 1'b0;
        end
    end

    assign bus.head  = mem[rd_ptr];
    assign bus.valid = (count != '0);
    assign bus.count = count;
    assign bus.ovf   = ovf;
endmodule

// File: tb/tb_mean_out_buffer.sv
// Directed bench: one buffer with DECIM=1 for FIFO behaviour, one with DECIM=3 for decimation.
module tb_mean_out_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mean_out_buffer_if #(.DATA_W(8), .DEPTH(8)) a ();
    mean_out_buffer_if #(.DATA_W(8), .DEPTH(8)) b ();

    mean_out_buffer #(.DATA_W(8), .DEPTH(8), .DECIM(1)) u_dut (.clk(clk), .rst(rst), .bus(a));
    mean_out_buffer #(.DATA_W(8), .DEPTH(8), .DECIM(3)) u_dec (.clk(clk), .rst(rst), .bus(b));

    typedef struct {
        logic       done;
        logic [7:0] data;
        logic       ready;
        logic       flush;
        logic       clr;
        logic       exp_valid;
        int         exp_head;
        int         exp_count;
        logic       exp_ovf;
        string      tag;
    } vec_t;

    vec_t tbl[$];
    int   kept[$];

    function automatic void add(input logic done, input int data, input logic ready,
                                input logic flush, input logic clr, input logic ev,
                                input int eh, input int ec, input logic eo, input string tag);
        vec_t v;
        v.done = done; v.data = 8'(data); v.ready = ready; v.flush = flush; v.clr = clr;
        v.exp_valid = ev; v.exp_head = eh; v.exp_count = ec; v.exp_ovf = eo; v.tag = tag;
        tbl.push_back(v);
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input vec_t v);
        a.done    = v.done;
        a.sample  = v.data;
        a.ready   = v.ready;
        a.flush   = v.flush;
        a.clr_ovf = v.clr;
        step();
    endtask

    task automatic drive_b(input logic en, input logic done, input int data);
        b.en     = en;
        b.done   = done;
        b.sample = 8'(data);
        step();
        if (b.valid) kept.push_back(int'(b.head));
    endtask

    initial begin
        int exp_kept[6];
        exp_kept = '{1, 4, 7, 10, 20, 30};

        a.en = 1'b1; a.sample = '0; a.done = 1'b0; a.flush = 1'b0; a.clr_ovf = 1'b0; a.ready = 1'b0;
        b.en = 1'b0; b.sample = '0; b.done = 1'b0; b.flush = 1'b0; b.clr_ovf = 1'b0; b.ready = 1'b1;

        step();
        check_output("reset_count", int'(a.count), 0);
        check_output("reset_valid", int'(a.valid), 0);
        check_output("reset_ovf",   int'(a.ovf),   0);
        check_output("reset_b_valid", int'(b.valid), 0);
        rst = 1'b0;

        // Basic stream: each sample is the head one cycle after its strobe, occupancy never above 1.
        a.ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            a.done = 1'b1; a.sample = 8'(i);
            step();
            check_output($sformatf("stream_valid_%0d", i), int'(a.valid), 1);
            check_output($sformatf("stream_head_%0d", i),  int'(a.head),  i);
            check_output($sformatf("stream_count_%0d", i), int'(a.count), 1);
            check_output($sformatf("stream_ovf_%0d", i),   int'(a.ovf),   0);
        end
        a.done = 1'b0;
        step();
        check_output("stream_empty", int'(a.valid), 0);
        a.ready = 1'b0;

        // Decimation by 3, then an enable gap restarts the phase.
        for (int i = 1; i <= 10; i++) drive_b(1'b1, 1'b1, i);
        drive_b(1'b1, 1'b0, 0);
        drive_b(1'b0, 1'b0, 0);
        for (int i = 20; i <= 22; i++) drive_b(1'b1, 1'b1, i);
        drive_b(1'b1, 1'b0, 0);
        drive_b(1'b1, 1'b1, 30);
        drive_b(1'b1, 1'b1, 31);
        drive_b(1'b1, 1'b0, 0);
        check_output("decim_kept_n", kept.size(), 6);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("decim_kept_%0d", i), (i < kept.size()) ? kept[i] : -1, exp_kept[i]);
        end

        for (int k = 1; k <= 8; k++) add(1, k, 0, 0, 0, 1, 1, k, 0, "fill");
        add(1, 9,  0, 0, 0, 1, 1, 8, 1, "ovf9");
        add(1, 10, 0, 0, 0, 1, 1, 8, 1, "ovf10");
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 0, k < 8, k + 1, 8 - k, 1, "drain");
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, "idle_empty");
        for (int k = 1; k <= 3; k++) add(1, 40 + k, 0, 0, 0, 1, 41, k, 1, "push3");
        add(1, 99, 0, 1, 0, 0, 0, 0, 1, "flush_wr");
        add(0, 0,  0, 0, 1, 0, 0, 0, 0, "clr");
        for (int k = 1; k <= 8; k++) add(1, 60 + k, 0, 0, 0, 1, 61, k, 0, "fill2");
        add(1, 70, 0, 0, 1, 1, 61, 8, 1, "set_beats_clr");
        add(0, 0,  0, 1, 0, 0, 0, 0, 1, "flush");
        add(0, 0,  0, 0, 1, 0, 0, 0, 0, "clr2");
        for (int k = 1; k <= 8; k++) add(1, k, 0, 0, 0, 1, 1, k, 0, "fill3");
        add(1, 9,  1, 0, 0, 1, 2, 8, 0, "full_pushpop");
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 0, 0, k < 8, k + 2, 8 - k, 0, "drain_pp");
        for (int k = 1; k <= 8; k++) add(1, k, 0, 0, 0, 1, 1, k, 0, "fill4");
        add(1, 9,  0, 0, 0, 1, 1, 8, 1, "ovf_pre_rst");
        for (int k = 1; k <= 3; k++) add(0, 0, 1, 0, 0, 1, k + 1, 8 - k, 1, "drain_to5");

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i]);
            check_output($sformatf("%s_%0d_valid", tbl[i].tag, i), int'(a.valid), int'(tbl[i].exp_valid));
            check_output($sformatf("%s_%0d_count", tbl[i].tag, i), int'(a.count), tbl[i].exp_count);
            check_output($sformatf("%s_%0d_ovf",   tbl[i].tag, i), int'(a.ovf),   int'(tbl[i].exp_ovf));
            if (tbl[i].exp_valid)
                check_output($sformatf("%s_%0d_head", tbl[i].tag, i), int'(a.head), tbl[i].exp_head);
        end

        // Reset with 5 entries stored and the consumer ready.
        a.done = 1'b0; a.ready = 1'b1; a.flush = 1'b0; a.clr_ovf = 1'b0;
        rst = 1'b1;
        step();
        check_output("midrst_count", int'(a.count), 0);
        check_output("midrst_valid", int'(a.valid), 0);
        check_output("midrst_ovf",   int'(a.ovf),   0);
        rst = 1'b0;

        // First strobe after reset is kept even though the DECIM=3 phase was mid-count.
        a.ready = 1'b0; a.done = 1'b1; a.sample = 8'd50;
        b.ready = 1'b0; b.en = 1'b1; b.done = 1'b1; b.sample = 8'd40;
        step();
        check_output("postrst_a_head",  int'(a.head),  50);
        check_output("postrst_a_count", int'(a.count), 1);
        check_output("postrst_b_valid", int'(b.valid), 1);
        check_output("postrst_b_head",  int'(b.head),  40);
        a.done = 1'b0; b.done = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mean_out_buffer.md
Name: mean_out_buffer

Overview:
Downstream stage of the mean filter. It takes the filter's 8-bit output samples, qualified by the filter's done strobe, and optionally decimates them. Kept samples go into a small first-word-fall-through FIFO, which is drained by a valid/ready consumer (serializer, DMA or debug port). Samples lost because the FIFO was full are reported through a sticky overflow flag.

Parameters:
DATA_W, 8, sample width; must match the filter output width.
DEPTH, 8, FIFO entries; power of two, at least 2.
DECIM, 1, keep one of every DECIM done strobes; legal range 1..16.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  reset, synchronous, active-high.
en_i  in  1  same enable that drives the mean filter; low clears the decimation phase.
data_i  in  DATA_W  filter output sample.
done_i  in  1  single-cycle strobe; data_i is valid in this cycle.
flush_i  in  1  synchronous FIFO clear.
clr_ovf_i  in  1  clears the sticky overflow flag.
data_o  out  DATA_W  head-of-FIFO sample.
valid_o  out  1  FIFO not empty.
ready_i  in  1  consumer accepts data_o when valid_o and ready_i are both high.
count_o  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
ovf_o  out  1  sticky flag: a kept sample was dropped.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: rd_ptr=0, wr_ptr=0, count_o=0, valid_o=0, ovf_o=0, decimation counter=0.
  - data_o is don't-care while valid_o=0. The bench must not check it.
- Decimation:
  - dcnt counts done_i pulses that arrive while en_i=1. It wraps from DECIM-1 to 0.
  - A pulse is kept when dcnt==0 at that edge, so the first sample after en_i rises is always kept.
  - en_i=0 forces dcnt=0 and ignores done_i.
  - DECIM=1 keeps every sample.
- Write request: wr_req = done_i & en_i & (dcnt==0).
- Pop: pop = valid_o & ready_i.
- Write accepted when wr_req and (count_o<DEPTH or pop).
  - Full with a simultaneous pop: both happen, and count_o stays at DEPTH.
- Overflow:
  - wr_req with count_o==DEPTH and no pop drops the sample.
  - ovf_o=1 from the next cycle. FIFO contents and pointers are unchanged.
  - ovf_o stays set until clr_ovf_i or rst.
  - If a set and clr_ovf_i occur in the same cycle, the set wins.
- Latency: a sample accepted at edge k gives valid_o=1 and data_o=sample in the cycle after edge k.
  - When the FIFO was empty, that sample is the head.
  - There is no same-cycle pass-through from data_i to data_o.
- Empty FIFO: pop is impossible. A write in this state only writes.
- count_o update rule: count_o += accepted_write − pop, registered.
- Pointers: log2(DEPTH) bits each, natural wrap-around. data_o = mem[rd_ptr].
- flush_i:
  - Next cycle: pointers=0, count_o=0, valid_o=0.
  - A simultaneous wr_req is discarded and does not set ovf_o. Any pop in that cycle is also discarded.
  - dcnt and ovf_o are unaffected.
- rst in mid-operation: all state returns to the reset values on the next edge. Entries already stored are lost.
- data_i is sampled only on accepted writes. It may change freely at other times.

Test Plan:
- Basic stream:
  - Stimulus: rst 1 cycle; en_i=1; DECIM=1; done_i every cycle with data_i=1..10; ready_i=1.
  - Required: data_o sequence 1..10, each appearing 1 cycle after its strobe; count_o never above 1; ovf_o=0.
- Fill and overflow:
  - Stimulus: ready_i=0; push 10 samples 1..10 with DEPTH=8.
  - Required: count_o=8; ovf_o=1 after the 9th strobe. Then ready_i=1 drains exactly 1..8, and valid_o=0 afterwards.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full with 1..8; one cycle with done_i (data 9) and ready_i high together.
  - Required: count_o stays 8; ovf_o stays 0; drain order is 2..9.
- Decimation:
  - Stimulus: DECIM=3; en_i=1; strobes with data 1..10.
  - Required: kept samples 1, 4, 7, 10.
  - Stimulus: drop en_i for 1 cycle, then send data 20..22.
  - Required: kept sample is 20.
- Flush and clear:
  - Stimulus: FIFO holding 3 entries with ovf_o=1; flush_i and wr_req in the same cycle.
  - Required: count_o=0, valid_o=0, ovf_o still 1.
  - Stimulus: clr_ovf_i.
  - Required: ovf_o=0. A clr_ovf_i in the same cycle as a new overflow leaves ovf_o=1.
- Reset mid-operation:
  - Stimulus: assert rst with 5 entries stored and ready_i=1.
  - Required: next cycle count_o=0, valid_o=0, ovf_o=0. The first post-reset strobe is kept regardless of DECIM.
